// File: rtl/uart_mmio_if.sv
// Bus slot signals between the system bus slot decoder (master) and
// the UART register front end (slave).
interface uart_mmio_if;
    logic        cs;
    logic        read;
    logic        write;
    logic [2:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (
        output cs, read, write, addr, wr_data,
        input  rd_data
    );

    modport slave (
        input  cs, read, write, addr, wr_data,
        output rd_data
    );
endinterface

// File: rtl/uart_mmio_ctrl.sv
// UART memory-mapped register front end.
// Turns single-cycle bus accesses into one-cycle FIFO push/pop pulses,
// holds the runtime line configuration and keeps sticky error status.
// Optional interrupt logic is enabled by defining UART_MMIO_IRQ_EN;
// without it register 6 reads 0 and irq is tied low.
module uart_mmio_ctrl #(
    parameter int DATA_BITS    = 8,
    parameter int DVSR_WIDTH   = 11,
    parameter int DEFAULT_DVSR = 650
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_mmio_if.slave            bus,
    output logic                  uart_rd,
    output logic                  uart_wr,
    output logic [DATA_BITS-1:0]  uart_wr_data,
    input  logic [DATA_BITS-1:0]  uart_rd_data,
    input  logic                  uart_tx_full,
    input  logic                  uart_rx_empty,
    input  logic                  parity_err,
    input  logic                  frame_err,
    input  logic                  overflow_err,
    output logic                  data_bit,
    output logic [1:0]            sb_ticks,
    output logic                  parity_en,
    output logic                  parity_pol,
    output logic [DVSR_WIDTH-1:0] dvsr,
    output logic                  irq
);

    localparam logic [2:0] A_STATUS  = 3'd0;
    localparam logic [2:0] A_DVSR    = 3'd1;
    localparam logic [2:0] A_TX      = 3'd2;
    localparam logic [2:0] A_POP     = 3'd3;
    localparam logic [2:0] A_CTRL    = 3'd4;
    localparam logic [2:0] A_ERR_CLR = 3'd5;
    localparam logic [2:0] A_IRQ_EN  = 3'd6;

    logic        rd_en, wr_en;
    logic        tx_req, tx_push, tx_drop, rx_pop;
    logic [3:0]  err_clr;
    logic        par_sticky, frm_sticky, ovf_sticky, drop_sticky;
    logic [1:0]  irq_en_reg;
    logic [31:0] rd_mux;
    logic        unused_wdata;

    // Upper write-data bits are not used by every register.
    assign unused_wdata = &{1'b0, bus.wr_data};

    assign rd_en   = bus.cs & bus.read;
    assign wr_en   = bus.cs & bus.write;
    assign tx_req  = wr_en & (bus.addr == A_TX);
    assign tx_push = tx_req & ~uart_tx_full;
    assign tx_drop = tx_req & uart_tx_full;
    assign rx_pop  = wr_en & (bus.addr == A_POP) & ~uart_rx_empty;
    assign err_clr = (wr_en && bus.addr == A_ERR_CLR) ? bus.wr_data[3:0] : 4'b0;

    // Read-data selection from the current register state; write-only and unused addresses read 0.
    always_comb begin
        rd_mux = 32'b0;
        case (bus.addr)
            A_STATUS: rd_mux = 32'(uart_rd_data)
                             | {18'b0, drop_sticky, ovf_sticky, frm_sticky, par_sticky,
                                uart_tx_full, uart_rx_empty, 8'b0};
            A_DVSR:   rd_mux = 32'(dvsr);
            A_CTRL:   rd_mux = {27'b0, parity_pol, parity_en, sb_ticks, data_bit};
            A_IRQ_EN: rd_mux = {30'b0, irq_en_reg};
            default:  rd_mux = 32'b0;
        endcase
    end

    // Bus read register, FIFO strobes, configuration and sticky error state.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rd_data  <= 32'b0;
            uart_wr      <= 1'b0;
            uart_rd      <= 1'b0;
            uart_wr_data <= '0;
            dvsr         <= DVSR_WIDTH'(DEFAULT_DVSR);
            data_bit     <= 1'b0;
            sb_ticks     <= 2'b0;
            parity_en    <= 1'b0;
            parity_pol   <= 1'b0;
            par_sticky   <= 1'b0;
            frm_sticky   <= 1'b0;
            ovf_sticky   <= 1'b0;
            drop_sticky  <= 1'b0;
        end else begin
            uart_wr <= tx_push;
            uart_rd <= rx_pop;
            if (rd_en)
                bus.rd_data <= rd_mux;
            if (tx_push)
                uart_wr_data <= bus.wr_data[DATA_BITS-1:0];
            if (wr_en && bus.addr == A_DVSR)
                dvsr <= bus.wr_data[DVSR_WIDTH-1:0];
            if (wr_en && bus.addr == A_CTRL)
                {parity_pol, parity_en, sb_ticks, data_bit} <= bus.wr_data[4:0];
            // A new error pulse in the same cycle as its clear keeps the bit set.
            par_sticky  <= parity_err   | (par_sticky  & ~err_clr[0]);
            frm_sticky  <= frame_err    | (frm_sticky  & ~err_clr[1]);
            ovf_sticky  <= overflow_err | (ovf_sticky  & ~err_clr[2]);
            drop_sticky <= tx_drop      | (drop_sticky & ~err_clr[3]);
        end
    end

`ifdef UART_MMIO_IRQ_EN
    // Interrupt enables and registered interrupt request.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_reg <= 2'b0;
            irq        <= 1'b0;
        end else begin
            if (wr_en && bus.addr == A_IRQ_EN)
                irq_en_reg <= bus.wr_data[1:0];
            irq <= (irq_en_reg[0] & ~uart_rx_empty)
                 | (irq_en_reg[1] & (par_sticky | frm_sticky | ovf_sticky | drop_sticky));
        end
    end
`else
    assign irq_en_reg = 2'b0;
    assign irq        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Testbench for uart_mmio_ctrl: directed vector table, hand-written
// interrupt sequence and randomized traffic against a register-map model.
module tb_uart_mmio_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        uart_rd, uart_wr;
    logic [7:0]  uart_wr_data;
    logic [7:0]  uart_rd_data = 8'h00;
    logic        uart_tx_full = 1'b0;
    logic        uart_rx_empty = 1'b1;
    logic        parity_err = 1'b0, frame_err = 1'b0, overflow_err = 1'b0;
    logic        data_bit, parity_en, parity_pol, irq;
    logic [1:0]  sb_ticks;
    logic [10:0] dvsr;

    int n_tests = 0;
    int n_fail  = 0;

    uart_mmio_if bus ();

    uart_mmio_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .uart_rd      (uart_rd),
        .uart_wr      (uart_wr),
        .uart_wr_data (uart_wr_data),
        .uart_rd_data (uart_rd_data),
        .uart_tx_full (uart_tx_full),
        .uart_rx_empty(uart_rx_empty),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .overflow_err (overflow_err),
        .data_bit     (data_bit),
        .sb_ticks     (sb_ticks),
        .parity_en    (parity_en),
        .parity_pol   (parity_pol),
        .dvsr         (dvsr),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    // Register-map model state: what each output should show after an edge.
    logic [31:0] m_rd;
    logic        m_wr, m_rdp, m_irq;
    logic [7:0]  m_wrd;
    logic [10:0] m_dvsr;
    logic [4:0]  m_ctrl;
    logic [3:0]  m_stk;   // [0] parity, [1] frame, [2] overflow, [3] drop
    logic [1:0]  m_ie;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [31:0] rv;
        logic [3:0]  clr, setv;
        if (reset) begin
            m_rd = 0; m_wr = 0; m_rdp = 0; m_wrd = 0; m_dvsr = 11'd650;
            m_ctrl = 0; m_stk = 0; m_ie = 0; m_irq = 0;
        end else begin
            case (bus.addr)
                3'd0: rv = (32'(m_stk) << 10) + (32'(uart_tx_full) << 9)
                           + (32'(uart_rx_empty) << 8) + 32'(uart_rd_data);
                3'd1: rv = 32'(m_dvsr);
                3'd4: rv = 32'(m_ctrl);
`ifdef UART_MMIO_IRQ_EN
                3'd6: rv = 32'(m_ie);
`endif
                default: rv = 0;
            endcase
            if (bus.cs && bus.read) m_rd = rv;
`ifdef UART_MMIO_IRQ_EN
            m_irq = (m_ie[0] && !uart_rx_empty) || (m_ie[1] && m_stk != 0);
`else
            m_irq = 0;
`endif
            m_wr = 0; m_rdp = 0; clr = 0;
            setv = {1'b0, overflow_err, frame_err, parity_err};
            if (bus.cs && bus.write) begin
                case (bus.addr)
                    3'd1: m_dvsr = bus.wr_data[10:0];
                    3'd2: if (!uart_tx_full) begin m_wr = 1; m_wrd = bus.wr_data[7:0]; end
                          else setv[3] = 1;
                    3'd3: m_rdp = !uart_rx_empty;
                    3'd4: m_ctrl = bus.wr_data[4:0];
                    3'd5: clr = bus.wr_data[3:0];
`ifdef UART_MMIO_IRQ_EN
                    3'd6: m_ie = bus.wr_data[1:0];
`endif
                    default: ;
                endcase
            end
            m_stk = (m_stk & ~clr) | setv;
        end
    endtask

    task automatic check_all();
        chk("rd_data", bus.rd_data, m_rd);
        chk("uart_wr", 32'(uart_wr), 32'(m_wr));
        chk("uart_rd", 32'(uart_rd), 32'(m_rdp));
        chk("uart_wr_data", 32'(uart_wr_data), 32'(m_wrd));
        chk("dvsr", 32'(dvsr), 32'(m_dvsr));
        chk("ctrl", 32'({parity_pol, parity_en, sb_ticks, data_bit}), 32'(m_ctrl));
        chk("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    typedef struct {
        bit        rst, cs, rd, wr;
        bit [2:0]  addr;
        bit [31:0] wd;
        bit        full, empty;
        bit [7:0]  rxb;
        bit [2:0]  err;      // [0] parity, [1] frame, [2] overflow
        bit [31:0] e_rd;
        bit        e_wr, e_rdp;
    } vec_t;

    vec_t vq[$];

    task automatic drive(input bit rst, input bit cs, input bit rd, input bit wr,
                         input bit [2:0] addr, input bit [31:0] wd, input bit full,
                         input bit empty, input bit [7:0] rxb, input bit [2:0] err);
        reset = rst; bus.cs = cs; bus.read = rd; bus.write = wr;
        bus.addr = addr; bus.wr_data = wd; uart_tx_full = full; uart_rx_empty = empty;
        uart_rd_data = rxb; parity_err = err[0]; frame_err = err[1]; overflow_err = err[2];
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        //            rst cs rd wr addr wd          full empty rxb    err   e_rd        e_wr e_rdp
        vq.push_back('{1, 0, 0, 0, 0, 32'h0,       0, 1, 8'h00, 3'b000, 32'h0,      0, 0});
        vq.push_back('{0, 1, 1, 0, 0, 32'h0,       0, 1, 8'h00, 3'b000, 32'h100,    0, 0});
        vq.push_back('{0, 1, 1, 0, 1, 32'h0,       0, 1, 8'h00, 3'b000, 32'h28A,    0, 0});
        vq.push_back('{0, 1, 1, 0, 4, 32'h0,       0, 1, 8'h00, 3'b000, 32'h0,      0, 0});
        vq.push_back('{0, 1, 0, 1, 2, 32'h41,      0, 1, 8'h00, 3'b000, 32'h0,      1, 0});
        vq.push_back('{0, 0, 0, 0, 0, 32'h0,       0, 1, 8'h00, 3'b000, 32'h0,      0, 0});
        vq.push_back('{0, 1, 0, 1, 2, 32'h42,      1, 1, 8'h00, 3'b000, 32'h0,      0, 0});
        vq.push_back('{0, 1, 1, 0, 0, 32'h0,       0, 1, 8'h00, 3'b000, 32'h2100,   0, 0});
        vq.push_back('{0, 1, 1, 0, 0, 32'h0,       0, 0, 8'h5A, 3'b000, 32'h205A,   0, 0});
        vq.push_back('{0, 1, 0, 1, 3, 32'h0,       0, 0, 8'h5A, 3'b000, 32'h205A,   0, 1});
        vq.push_back('{0, 1, 0, 1, 3, 32'h0,       0, 1, 8'h00, 3'b000, 32'h205A,   0, 0});
        vq.push_back('{0, 1, 0, 1, 4, 32'h1F,      0, 1, 8'h00, 3'b000, 32'h205A,   0, 0});
        vq.push_back('{0, 1, 0, 1, 1, 32'h7FF,     0, 1, 8'h00, 3'b000, 32'h205A,   0, 0});
        vq.push_back('{0, 1, 1, 0, 4, 32'h0,       0, 1, 8'h00, 3'b000, 32'h1F,     0, 0});
        vq.push_back('{0, 1, 1, 0, 1, 32'h0,       0, 1, 8'h00, 3'b000, 32'h7FF,    0, 0});
        vq.push_back('{0, 0, 0, 0, 0, 32'h0,       0, 1, 8'h00, 3'b010, 32'h7FF,    0, 0});
        vq.push_back('{0, 1, 1, 0, 0, 32'h0,       0, 1, 8'h00, 3'b000, 32'h2900,   0, 0});
        vq.push_back('{0, 1, 0, 1, 5, 32'h2,       0, 1, 8'h00, 3'b010, 32'h2900,   0, 0});
        vq.push_back('{0, 1, 1, 0, 0, 32'h0,       0, 1, 8'h00, 3'b000, 32'h2900,   0, 0});
        vq.push_back('{0, 1, 0, 1, 5, 32'h2,       0, 1, 8'h00, 3'b000, 32'h2900,   0, 0});
        vq.push_back('{0, 1, 1, 0, 0, 32'h0,       0, 1, 8'h00, 3'b000, 32'h2100,   0, 0});
        vq.push_back('{0, 1, 0, 1, 5, 32'hF,       0, 1, 8'h00, 3'b000, 32'h2100,   0, 0});
        vq.push_back('{0, 1, 1, 0, 0, 32'h0,       0, 1, 8'h00, 3'b000, 32'h100,    0, 0});
        vq.push_back('{0, 1, 1, 0, 7, 32'h0,       0, 1, 8'h00, 3'b000, 32'h0,      0, 0});
        vq.push_back('{0, 0, 1, 1, 2, 32'h55,      0, 1, 8'h00, 3'b000, 32'h0,      0, 0});
        vq.push_back('{0, 1, 1, 1, 2, 32'h33,      0, 1, 8'h00, 3'b000, 32'h0,      1, 0});
        vq.push_back('{0, 1, 0, 1, 2, 32'h34,      0, 1, 8'h00, 3'b000, 32'h0,      1, 0});
        vq.push_back('{0, 1, 1, 0, 0, 32'h0,       0, 1, 8'h00, 3'b000, 32'h100,    0, 0});
        vq.push_back('{1, 1, 0, 1, 2, 32'h66,      0, 0, 8'h00, 3'b000, 32'h0,      0, 0});

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].cs, vq[i].rd, vq[i].wr, vq[i].addr, vq[i].wd,
                  vq[i].full, vq[i].empty, vq[i].rxb, vq[i].err);
            tick();
            chk($sformatf("vec%0d rd_data", i), bus.rd_data, vq[i].e_rd);
            chk($sformatf("vec%0d uart_wr", i), 32'(uart_wr), 32'(vq[i].e_wr));
            chk($sformatf("vec%0d uart_rd", i), 32'(uart_rd), 32'(vq[i].e_rdp));
            if (i == 4) chk("vec4 uart_wr_data", 32'(uart_wr_data), 32'h41);
            if (i == 12) chk("vec12 dvsr", 32'(dvsr), 32'd2047);
            if (i == 11) chk("vec11 ctrl ports", 32'({data_bit, sb_ticks, parity_en, parity_pol}), 32'h1F);
        end

        // Interrupt sequence.
        drive(0, 1, 0, 1, 6, 32'h1, 0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
`ifdef UART_MMIO_IRQ_EN
        chk("irq rx set", 32'(irq), 32'd1);
`else
        chk("irq tied low", 32'(irq), 32'd0);
`endif
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        chk("irq rx clear", 32'(irq), 32'd0);
        drive(0, 1, 0, 1, 6, 32'h2, 0, 1, 0, 3'b001);
        tick();
        drive(0, 1, 1, 0, 6, 0, 0, 1, 0, 0);
        tick();
`ifdef UART_MMIO_IRQ_EN
        chk("irq err set", 32'(irq), 32'd1);
        chk("irq_en readback", bus.rd_data, 32'h2);
`else
        chk("irq err tied low", 32'(irq), 32'd0);
        chk("irq_en readback", bus.rd_data, 32'h0);
`endif
        drive(0, 1, 0, 1, 5, 32'h1, 0, 1, 0, 0);
        tick();
        tick();
        chk("irq err clear", 32'(irq), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom % 64) == 0, ($urandom % 4) != 0, $urandom % 2, $urandom % 2,
                  3'($urandom % 8), $urandom, ($urandom % 3) == 0, ($urandom % 2) == 0,
                  8'($urandom), {($urandom % 16) == 0, ($urandom % 16) == 0, ($urandom % 16) == 0});
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_mmio_ctrl.md
Name: uart_mmio_ctrl

Overview:
Bus-side register front end that drives the UART core's host interface (FIFO read/write strobes, data, configuration) from a memory-mapped slot. Converts single-cycle bus reads/writes into one-cycle FIFO pop/push pulses. Holds the runtime configuration registers (divisor, data bits, stop bits, parity). Captures the core's error pulses into sticky status bits. Sits between the system bus slot decoder and the UART core.

Parameters:
DATA_BITS, 8, UART data width; must match the core
DVSR_WIDTH, 11, baud divisor width
DEFAULT_DVSR, 650, divisor loaded at reset (9600 baud at 100 MHz, 16x oversampling)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cs  in  1  slot select
read  in  1  bus read strobe; valid only with cs
write  in  1  bus write strobe; valid only with cs
addr  in  3  register word address
wr_data  in  32  bus write data
rd_data  out  32  bus read data, registered
uart_rd  out  1  RX FIFO pop pulse
uart_wr  out  1  TX FIFO push pulse
uart_wr_data  out  DATA_BITS  byte to push
uart_rd_data  in  DATA_BITS  RX FIFO head
uart_tx_full  in  1  TX FIFO full
uart_rx_empty  in  1  RX FIFO empty
parity_err, frame_err, overflow_err  in  1 each  error pulses from the core
data_bit  out  1  0 = 8 data bits, 1 = 7 data bits
sb_ticks  out  2  stop-bit select
parity_en, parity_pol  out  1 each  parity configuration
dvsr  out  DVSR_WIDTH  baud divisor
irq  out  1  interrupt request

Behaviour:
- Clock is clk. Reset is synchronous and active-high, named reset.
- Register map:
  - 0 STATUS (R): [7:0] uart_rd_data, [8] uart_rx_empty, [9] uart_tx_full, [10] par_sticky, [11] frm_sticky, [12] ovf_sticky, [13] drop_sticky; all other bits 0. Reading does not pop.
  - 1 DVSR (R/W): [DVSR_WIDTH-1:0].
  - 2 TX (W): [7:0] byte to send.
  - 3 POP (W): any write data pops the RX FIFO.
  - 4 CTRL (R/W): [0] data_bit, [2:1] sb_ticks, [3] parity_en, [4] parity_pol.
  - 5 ERR_CLR (W1C): bits [3:0] clear par/frm/ovf/drop sticky bits.
  - 6 IRQ_EN: see Optional Feature.
  - Reads of 7, and of write-only addresses, return 0.
- Reset values: rd_data=0, uart_rd=0, uart_wr=0, uart_wr_data=0, dvsr=DEFAULT_DVSR, data_bit=0, sb_ticks=0, parity_en=0, parity_pol=0, all sticky bits=0, irq=0.
- Reads: rd_data updates the cycle after cs&read, so latency is 1. rd_data holds its value when no read is performed.
- TX push: on cs&write&addr==2 with uart_tx_full=0:
  - uart_wr_data <= wr_data[7:0].
  - uart_wr=1 for exactly the next cycle.
- TX drop: if uart_tx_full=1 at the write cycle, no pulse is issued and drop_sticky is set.
- Back-to-back TX writes produce back-to-back pulses. Each write is gated by uart_tx_full sampled in its own cycle.
- Pop: on cs&write&addr==3 with uart_rx_empty=0, uart_rd=1 for exactly the next cycle. A pop while empty is ignored and has no flag.
- Config writes (1, 4) take effect the cycle after the write. Software changes config only when both FIFOs are idle; the block does not enforce this.
- Sticky bits:
  - Each is set on any cycle its input pulse (or drop condition) is high.
  - Cleared by ERR_CLR with the corresponding bit=1.
  - Simultaneous set and clear in the same cycle: set wins.
- cs low: read and write are ignored and no strobes are issued.
- read and write together: the write executes and rd_data is also updated.
- Reset mid-operation: any pending uart_wr/uart_rd pulse is suppressed in the reset cycle. Reset forces all outputs to their reset values.

Optional Feature:
Macro UART_MMIO_IRQ_EN.
- Defined:
  - Register 6 is R/W: [0] rx_ie, [1] err_ie; reset value 0.
  - irq is registered: irq <= (rx_ie & ~uart_rx_empty) | (err_ie & any sticky bit).
  - irq deasserts one cycle after the cause clears.
- Undefined:
  - Register 6 reads 0 and ignores writes.
  - irq is tied to 0.

Test Plan:
- Reset, then read addresses 0, 1 and 4 -> STATUS shows bit8=1 with uart_rx_empty=1; DVSR reads 650; CTRL reads 0; dvsr port=650.
- Write 0x41 to addr 2 with uart_tx_full=0 -> uart_wr high exactly 1 cycle, uart_wr_data=0x41. Repeat with uart_tx_full=1 -> no pulse, STATUS[13]=1.
- uart_rx_empty=0 and uart_rd_data=0x5A: read addr 0 -> rd_data[7:0]=0x5A one cycle later and no pop. Then write addr 3 -> single uart_rd pulse. Write addr 3 with uart_rx_empty=1 -> no pulse.
- Write CTRL=0x1F -> data_bit=1, sb_ticks=3, parity_en=1, parity_pol=1. Write DVSR=0x7FF -> dvsr=2047.
- Pulse frame_err for 1 cycle -> STATUS[11]=1 and persists. ERR_CLR=0x2 in the same cycle as a new frame_err pulse -> remains 1. ERR_CLR=0x2 alone -> 0.
- With UART_MMIO_IRQ_EN defined: IRQ_EN=1, then deassert uart_rx_empty -> irq=1 next cycle; uart_rx_empty=1 -> irq=0 next cycle. Without the macro -> irq stays 0.
